// File: rtl/hub75_pkg.sv
// rtl/hub75_pkg.sv - shared HUB75 receiver types, accumulator word layout and address packing
package hub75_pkg;
  localparam int DEF_NUM_ROWS = 16;
  localparam int DEF_PLANES   = 255;
  localparam int ROW_W        = 4;
  localparam int COL_W        = 6;
  localparam int NUM_CH       = 6;

  // Channel slice c of the accumulator word sits at [c*PIXEL_DEPTH +: PIXEL_DEPTH];
  // index c also equals the bit position of that channel in {rgb1, rgb2}.
  localparam int CH_UR = 5;
  localparam int CH_UG = 4;
  localparam int CH_UB = 3;
  localparam int CH_LR = 2;
  localparam int CH_LG = 1;
  localparam int CH_LB = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_DONE
  } rx_state_t;

  function automatic logic [ROW_W+COL_W-1:0] acc_pack(input logic [ROW_W-1:0] row,
                                                      input logic [COL_W-1:0] col);
    return {row, col};
  endfunction
endpackage

// File: rtl/hub75_rx_capture.sv
// rtl/hub75_rx_capture.sv - panel clock/latch edge detection, shift buffer and hold buffer
module hub75_rx_capture
  import hub75_pkg::*;
#(
  parameter int IMG_WIDTH      = 64,
  parameter int IMG_WIDTH_LOG2 = COL_W
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_panel_clk,
  input  logic                             i_panel_lat,
  input  logic [2:0]                       i_rgb1,
  input  logic [2:0]                       i_rgb2,
  input  logic [ROW_W-1:0]                 i_led_addr,
  input  logic                             i_busy,
  output logic [IMG_WIDTH-1:0][NUM_CH-1:0] o_hold,
  output logic [ROW_W-1:0]                 o_row,
  output logic                             o_latch,
  output logic                             o_err
);
  localparam logic [IMG_WIDTH_LOG2:0] COL_FULL = (IMG_WIDTH_LOG2+1)'(IMG_WIDTH);

  logic                             r_clk_prev;
  logic                             r_lat_prev;
  logic [IMG_WIDTH-1:0][NUM_CH-1:0] r_shift;
  logic [IMG_WIDTH-1:0][NUM_CH-1:0] r_hold;
  logic [IMG_WIDTH_LOG2:0]          r_col;
  logic [ROW_W-1:0]                 r_row;
  logic                             r_latch;
  logic                             r_err;
  logic                             w_clk_rise;
  logic                             w_lat_rise;
  logic                             w_lat_take;
  logic                             w_col_full;

  assign w_clk_rise = i_panel_clk & ~r_clk_prev;
  assign w_lat_rise = i_panel_lat & ~r_lat_prev;
  assign w_lat_take = w_lat_rise & ~i_busy;
  assign w_col_full = (r_col == COL_FULL);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_clk_prev <= 1'b0;
      r_lat_prev <= 1'b0;
      r_shift    <= '0;
      r_hold     <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_latch    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_clk_prev <= i_panel_clk;
      r_lat_prev <= i_panel_lat;
      r_latch    <= w_lat_take;
      r_err      <= (w_lat_rise & i_busy) | (w_clk_rise & w_col_full & ~w_lat_take);
      // A shift coinciding with an accepted latch starts the next row at column 0.
      if (w_lat_take) begin
        r_hold  <= r_shift;
        r_row   <= i_led_addr;
        r_shift <= '0;
        r_col   <= '0;
        if (w_clk_rise) begin
          r_shift[0] <= {i_rgb1, i_rgb2};
          r_col      <= (IMG_WIDTH_LOG2+1)'(1);
        end
      end else if (w_clk_rise && !w_col_full) begin
        r_shift[r_col[IMG_WIDTH_LOG2-1:0]] <= {i_rgb1, i_rgb2};
        r_col <= r_col + (IMG_WIDTH_LOG2+1)'(1);
      end
    end
  end

  assign o_hold  = r_hold;
  assign o_row   = r_row;
  assign o_latch = r_latch;
  assign o_err   = r_err;
endmodule

// File: rtl/hub75_rx.sv
// rtl/hub75_rx.sv - HUB75 receiver top: plane accumulation FSM and accumulator RAM port
// Optional HUB75_RX_SATURATE_EN: per-channel adds clamp at full scale instead of wrapping.
module hub75_rx
  import hub75_pkg::*;
#(
  parameter int PIXEL_DEPTH    = 8,
  parameter int IMG_WIDTH      = 64,
  parameter int IMG_WIDTH_LOG2 = COL_W,
  parameter int NUM_ROWS       = DEF_NUM_ROWS,
  parameter int PLANES         = DEF_PLANES,
  parameter int DATA_WIDTH     = 6 * PIXEL_DEPTH
) (
  input  logic                            clk_in,
  input  logic                            rst,
  input  logic                            panel_clk,
  input  logic                            panel_lat,
  input  logic                            panel_oe,
  input  logic [2:0]                      rgb1,
  input  logic [2:0]                      rgb2,
  input  logic [ROW_W-1:0]                led_addr,
  output logic [ROW_W+IMG_WIDTH_LOG2-1:0] acc_addr,
  output logic                            acc_we,
  output logic [DATA_WIDTH-1:0]           acc_wdata,
  input  logic [DATA_WIDTH-1:0]           acc_rdata,
  output logic                            frame_done,
  output logic                            busy,
  output logic                            overrun
);
  localparam int SUB_W = IMG_WIDTH_LOG2 + 1;
  localparam int CNT_W = $clog2(PLANES * NUM_ROWS + 1);
  localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(2 * IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PLANES * NUM_ROWS - 1);
  localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(NUM_ROWS);

  rx_state_t                        r_state;
  logic [SUB_W-1:0]                 r_sub;
  logic [CNT_W-1:0]                 r_lat_cnt;
  logic                             r_first;
  logic                             r_busy;
  logic                             r_frame_done;
  logic                             r_overrun;
  logic                             r_we;
  logic [ROW_W+IMG_WIDTH_LOG2-1:0]  r_addr;
  logic [IMG_WIDTH-1:0][NUM_CH-1:0] w_hold;
  logic [ROW_W-1:0]                 w_row;
  logic                             w_latch;
  logic                             w_err;
  logic [SUB_W-1:0]                 w_sub_nxt;
  logic [NUM_CH-1:0]                w_hold_col;
  logic [DATA_WIDTH-1:0]            w_wdata;

  hub75_rx_capture #(
    .IMG_WIDTH     (IMG_WIDTH),
    .IMG_WIDTH_LOG2(IMG_WIDTH_LOG2)
  ) u_capture (
    .i_clk      (clk_in),
    .i_rst      (rst),
    .i_panel_clk(panel_clk),
    .i_panel_lat(panel_lat),
    .i_rgb1     (rgb1),
    .i_rgb2     (rgb2),
    .i_led_addr (led_addr),
    .i_busy     (r_busy | w_latch),
    .o_hold     (w_hold),
    .o_row      (w_row),
    .o_latch    (w_latch),
    .o_err      (w_err)
  );

  function automatic logic [PIXEL_DEPTH-1:0] ch_add(input logic [PIXEL_DEPTH-1:0] a,
                                                    input logic b);
`ifdef HUB75_RX_SATURATE_EN
    logic [PIXEL_DEPTH:0] s;
    s = {1'b0, a} + (PIXEL_DEPTH+1)'(b);
    return s[PIXEL_DEPTH] ? '1 : s[PIXEL_DEPTH-1:0];
`else
    return a + PIXEL_DEPTH'(b);
`endif
  endfunction

  assign w_sub_nxt = r_sub + SUB_W'(1);

  // Write data follows the read issued on the same address one cycle earlier.
  always_comb begin
    w_hold_col = w_hold[r_addr[IMG_WIDTH_LOG2-1:0]];
    w_wdata    = '0;
    if (r_we) begin
      for (int c = CH_LB; c <= CH_UR; c++) begin
        w_wdata[c*PIXEL_DEPTH +: PIXEL_DEPTH] = r_first ? PIXEL_DEPTH'(w_hold_col[c])
            : ch_add(acc_rdata[c*PIXEL_DEPTH +: PIXEL_DEPTH], w_hold_col[c]);
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_sub        <= '0;
      r_lat_cnt    <= '0;
      r_first      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
    end else begin
      r_frame_done <= 1'b0;
      r_overrun    <= r_overrun | w_err;
      case (r_state)
        ST_IDLE: begin
          if (w_latch) begin
            r_state <= ST_ACC;
            r_busy  <= 1'b1;
            r_sub   <= '0;
            r_first <= (r_lat_cnt < CNT_FIRST);
            r_addr  <= acc_pack(w_row, '0);
            r_we    <= 1'b0;
          end
        end
        ST_ACC: begin
          if (r_sub == SUB_LAST) begin
            r_state <= ST_DONE;
            r_addr  <= '0;
            r_we    <= 1'b0;
          end else begin
            r_sub  <= w_sub_nxt;
            r_addr <= acc_pack(w_row, w_sub_nxt[IMG_WIDTH_LOG2:1]);
            r_we   <= w_sub_nxt[0];
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          if (r_lat_cnt == CNT_LAST) begin
            r_lat_cnt    <= '0;
            r_frame_done <= 1'b1;
          end else begin
            r_lat_cnt <= r_lat_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign acc_addr   = r_addr;
  assign acc_we     = r_we;
  assign acc_wdata  = w_wdata;
  assign frame_done = r_frame_done;
  assign busy       = r_busy;
  assign overrun    = r_overrun;
endmodule

// File: tb/tb_hub75_rx.sv
// tb/tb_hub75_rx.sv - randomized self-checking bench for hub75_rx against a plane-level image model
module tb_hub75_rx;
  localparam int W  = 64;
  localparam int NR = 16;
  localparam int PL = 4;
  localparam int DW = 48;
  localparam int NW = NR * W;
`ifdef HUB75_RX_SATURATE_EN
  localparam logic [7:0] WRAP_EXP = 8'hFF;
`else
  localparam logic [7:0] WRAP_EXP = 8'h00;
`endif

  logic          clk_in = 1'b0;
  logic          rst = 1'b1;
  logic          panel_clk = 1'b0;
  logic          panel_lat = 1'b0;
  logic          panel_oe = 1'b0;
  logic [2:0]    rgb1 = '0;
  logic [2:0]    rgb2 = '0;
  logic [3:0]    led_addr = '0;
  logic [9:0]    acc_addr;
  logic          acc_we;
  logic [DW-1:0] acc_wdata;
  logic [DW-1:0] acc_rdata;
  logic          frame_done;
  logic          busy;
  logic          overrun;

  always #5 clk_in = ~clk_in;

  hub75_rx #(.PLANES(PL)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .panel_clk (panel_clk),
    .panel_lat (panel_lat),
    .panel_oe  (panel_oe),
    .rgb1      (rgb1),
    .rgb2      (rgb2),
    .led_addr  (led_addr),
    .acc_addr  (acc_addr),
    .acc_we    (acc_we),
    .acc_wdata (acc_wdata),
    .acc_rdata (acc_rdata),
    .frame_done(frame_done),
    .busy      (busy),
    .overrun   (overrun)
  );

  // accumulator RAM with one-cycle read latency and a bench-side poke port
  logic [DW-1:0] ram [0:NW-1];
  logic          ram_clr = 1'b0;
  logic          poke_en = 1'b0;
  logic [9:0]    poke_addr = '0;
  logic [DW-1:0] poke_data = '0;
  always @(posedge clk_in) begin
    if (ram_clr) begin
      for (int i = 0; i < NW; i++) ram[i] <= '0;
    end else if (poke_en) begin
      ram[poke_addr] <= poke_data;
    end else if (acc_we) begin
      ram[acc_addr] <= acc_wdata;
    end
    acc_rdata <= ram[acc_addr];
  end

  int fd_cnt = 0;
  always @(negedge clk_in) if (frame_done) fd_cnt++;

  int errors = 0;
  int checks = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // image model: per pixel per channel on-counts, with first-pass overwrite
  int exp_ch [0:NW-1][0:5];
  int buf_px [0:W-1];
  int buf_n = 0;
  int m_lat = 0;
  int m_frames = 0;

  function automatic int m_add(input int a, input int b);
`ifdef HUB75_RX_SATURATE_EN
    return (a + b > 255) ? 255 : a + b;
`else
    return (a + b) % 256;
`endif
  endfunction

  task automatic m_clear_buf();
    for (int i = 0; i < W; i++) buf_px[i] = 0;
    buf_n = 0;
  endtask

  task automatic m_shift(input int p);
    if (buf_n < W) begin
      buf_px[buf_n] = p;
      buf_n++;
    end
  endtask

  task automatic m_latch(input int row);
    for (int col = 0; col < W; col++) begin
      for (int c = 0; c < 6; c++) begin
        int b = (buf_px[col] >> c) & 1;
        int idx = row * W + col;
        exp_ch[idx][c] = (m_lat < NR) ? b : m_add(exp_ch[idx][c], b);
      end
    end
    m_clear_buf();
    m_lat++;
    if (m_lat == PL * NR) begin
      m_lat = 0;
      m_frames++;
    end
  endtask

  function automatic logic [DW-1:0] m_word(input int idx);
    logic [DW-1:0] w = '0;
    for (int c = 0; c < 6; c++) w[c*8 +: 8] = 8'(exp_ch[idx][c]);
    return w;
  endfunction

  task automatic tick();
    @(negedge clk_in);
  endtask

  task automatic drv_shift(input int p);
    logic [5:0] pv = p[5:0];
    rgb1 = pv[5:3];
    rgb2 = pv[2:0];
    panel_clk = 1'b1;
    tick();
    panel_clk = 1'b0;
    tick();
    m_shift(p);
  endtask

  task automatic drv_latch(input int row, input bit accepted);
    logic [31:0] rv = row;
    led_addr = rv[3:0];
    panel_lat = 1'b1;
    tick();
    panel_lat = 1'b0;
    if (accepted) m_latch(row);
  endtask

  task automatic drv_latch_shift(input int row, input int p);
    logic [31:0] rv = row;
    logic [5:0] pv = p[5:0];
    led_addr = rv[3:0];
    rgb1 = pv[5:3];
    rgb2 = pv[2:0];
    panel_lat = 1'b1;
    panel_clk = 1'b1;
    tick();
    panel_lat = 1'b0;
    panel_clk = 1'b0;
    tick();
    m_latch(row);
    m_shift(p);
  endtask

  task automatic wait_idle(output int len);
    int n = 0;
    len = 0;
    while (!busy && n < 10) begin
      tick();
      n++;
    end
    if (!busy) chk("busy_start", busy, 1);
    while (busy && len < 400) begin
      tick();
      len++;
    end
    if (busy) chk("busy_timeout", busy, 0);
    tick();
  endtask

  task automatic rand_row(input int row, input bit full);
    int n = full ? W : int'($urandom_range(0, W));
    int len;
    for (int i = 0; i < n; i++) drv_shift(int'($urandom_range(0, 63)));
    drv_latch(row, 1'b1);
    wait_idle(len);
  endtask

  task automatic poke(input int idx, input logic [DW-1:0] data);
    poke_en = 1'b1;
    poke_addr = idx[9:0];
    poke_data = data;
    tick();
    poke_en = 1'b0;
  endtask

  task automatic ram_compare(input string tag);
    for (int i = 0; i < NW; i++) chk($sformatf("%s ram[%0d]", tag, i), ram[i], m_word(i));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

  initial begin
    int len;
    for (int i = 0; i < NW; i++) for (int c = 0; c < 6; c++) exp_ch[i][c] = 0;
    m_clear_buf();
    ram_clr = 1'b1;
    repeat (3) tick();
    chk("rst acc_addr", acc_addr, 0);
    chk("rst acc_we", acc_we, 0);
    chk("rst acc_wdata", acc_wdata, 0);
    chk("rst frame_done", frame_done, 0);
    chk("rst busy", busy, 0);
    chk("rst overrun", overrun, 0);
    ram_clr = 1'b0;
    rst = 1'b0;
    tick();

    // frame A: first row is a fixed pattern, then random rows
    for (int i = 0; i < W; i++) drv_shift(6'b100001);
    drv_latch(5, 1'b1);
    wait_idle(len);
    chk("busy_len", len, 129);
    for (int col = 0; col < W; col++)
      chk($sformatf("row5 col%0d", col), ram[5*W+col], 48'h010000000001);
    for (int k = 1; k < PL * NR - 1; k++) rand_row(int'($urandom_range(0, NR-1)), 1'b0);
    chk("frameA fd_before", fd_cnt, 0);
    rand_row(int'($urandom_range(0, NR-1)), 1'b0);
    chk("frameA fd_after", fd_cnt, 1);
    chk("frameA overrun", overrun, 0);
    ram_compare("frameA");

    // frame B: dropped latch, wrap/saturate, shift coinciding with latch
    for (int i = 0; i < 40; i++) drv_shift(int'($urandom_range(0, 63)));
    drv_latch(8, 1'b1);
    repeat (19) tick();
    drv_latch(9, 1'b0);
    wait_idle(len);
    chk("drop overrun", overrun, 1);
    for (int k = 1; k < PL * NR - 1; k++) begin
      if (k == 20) begin
        for (int col = 0; col < W; col++) begin
          exp_ch[3*W+col][5] = 255;
          poke(3*W+col, m_word(3*W+col));
        end
        for (int i = 0; i < W; i++) drv_shift(6'b100000);
        drv_latch(3, 1'b1);
        wait_idle(len);
        for (int col = 0; col < W; col++)
          chk($sformatf("wrap ur col%0d", col), ram[3*W+col][47:40], WRAP_EXP);
      end else if (k == 30) begin
        for (int i = 0; i < 30; i++) drv_shift(int'($urandom_range(0, 63)));
        drv_latch_shift(11, int'($urandom_range(1, 63)));
        wait_idle(len);
      end else begin
        rand_row(int'($urandom_range(0, NR-1)), 1'b0);
      end
    end
    chk("frameB fd_before", fd_cnt, 1);
    rand_row(int'($urandom_range(0, NR-1)), 1'b0);
    chk("frameB fd_after", fd_cnt, 2);
    ram_compare("frameB");

    // reset in the middle of an accumulation pass
    for (int i = 0; i < W; i++) drv_shift(int'($urandom_range(0, 63)));
    drv_latch(9, 1'b1);
    repeat (30) tick();
    chk("pre_rst busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst acc_addr", acc_addr, 0);
    chk("mid_rst acc_we", acc_we, 0);
    chk("mid_rst acc_wdata", acc_wdata, 0);
    chk("mid_rst busy", busy, 0);
    chk("mid_rst overrun", overrun, 0);
    tick();
    rst = 1'b0;
    tick();
    m_lat = 0;
    m_clear_buf();

    // frame C first pass: every row overwritten, row 7 gets 70 shifts
    for (int r = 0; r < NR; r++) begin
      if (r == 7) begin
        chk("pre70 overrun", overrun, 0);
        for (int i = 0; i < 70; i++) drv_shift(int'($urandom_range(0, 63)));
        drv_latch(7, 1'b1);
        wait_idle(len);
        chk("post70 overrun", overrun, 1);
      end else begin
        rand_row(r, 1'b1);
      end
    end
    chk("frameC fd", fd_cnt, 2);
    ram_compare("frameC");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
